// File: rtl/reg_ctx_engine.sv
// Context save/restore sequencer for the 32x32 register file.
// Save streams registers FIRST_REG..LAST_REG out to memory at base+4n.
// Restore reads the same window back and writes it into the register file.
module reg_ctx_engine #(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_save_i,
    input  logic        start_restore_i,
    input  logic [31:0] base_addr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [4:0]  rf_rd_reg_o,
    input  logic [31:0] rf_rd_data_i,
    output logic [4:0]  rf_wr_reg_o,
    output logic [31:0] rf_wr_data_o,
    output logic        rf_reg_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_REQ,
        RESTORE_REQ,
        RESTORE_WB,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] base_q, base_d;
    logic [31:0] cap_q, cap_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_read_q, mem_read_d;
    logic        rf_reg_write_q, rf_reg_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [4:0]  rf_rd_reg_q, rf_rd_reg_d;
    logic [4:0]  rf_wr_reg_q, rf_wr_reg_d;

    // Next-state logic, with every output computed from the upcoming state so it can be registered
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        base_d         = base_q;
        cap_d          = cap_q;
        busy_d         = 1'b0;
        done_d         = 1'b0;
        mem_write_d    = 1'b0;
        mem_read_d     = 1'b0;
        rf_reg_write_d = 1'b0;
        mem_addr_d     = mem_addr_q;
        rf_rd_reg_d    = rf_rd_reg_q;
        rf_wr_reg_d    = rf_wr_reg_q;

        case (state_q)
            IDLE: begin
                if (start_save_i) begin
                    state_d = SAVE_REQ;
                    base_d  = {base_addr_i[31:2], 2'b00};
                    idx_d   = FIRST_IDX;
                end else if (start_restore_i) begin
                    state_d = RESTORE_REQ;
                    base_d  = {base_addr_i[31:2], 2'b00};
                    idx_d   = FIRST_IDX;
                end
            end
            SAVE_REQ: begin
                if (mem_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            RESTORE_REQ: begin
                if (mem_ready_i) begin
                    cap_d   = mem_rdata_i;
                    state_d = RESTORE_WB;
                end
            end
            RESTORE_WB: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = RESTORE_REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            SAVE_REQ: begin
                busy_d      = 1'b1;
                mem_write_d = 1'b1;
                rf_rd_reg_d = idx_d;
                mem_addr_d  = base_d + {25'b0, idx_d, 2'b00};
            end
            RESTORE_REQ: begin
                busy_d     = 1'b1;
                mem_read_d = 1'b1;
                mem_addr_d = base_d + {25'b0, idx_d, 2'b00};
            end
            RESTORE_WB: begin
                busy_d         = 1'b1;
                rf_reg_write_d = 1'b1;
                rf_wr_reg_d    = idx_d;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, index, latched base, capture word and registered outputs; reset clears everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= FIRST_IDX;
            base_q         <= '0;
            cap_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            rf_reg_write_q <= 1'b0;
            mem_addr_q     <= '0;
            rf_rd_reg_q    <= '0;
            rf_wr_reg_q    <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            base_q         <= base_d;
            cap_q          <= cap_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            mem_write_q    <= mem_write_d;
            mem_read_q     <= mem_read_d;
            rf_reg_write_q <= rf_reg_write_d;
            mem_addr_q     <= mem_addr_d;
            rf_rd_reg_q    <= rf_rd_reg_d;
            rf_wr_reg_q    <= rf_wr_reg_d;
        end
    end

    // A reset arriving during the write-back cycle must suppress that write, so gate the enable with rst
    assign rf_reg_write_o = rf_reg_write_q & ~rst;
    // Save data passes straight through from the register file while the write request is up
    assign mem_wdata_o    = mem_write_q ? rf_rd_data_i : 32'h0;

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign mem_write_o  = mem_write_q;
    assign mem_read_o   = mem_read_q;
    assign mem_addr_o   = mem_addr_q;
    assign rf_rd_reg_o  = rf_rd_reg_q;
    assign rf_wr_reg_o  = rf_wr_reg_q;
    assign rf_wr_data_o = cap_q;

endmodule

// File: tb/tb_reg_ctx_engine.sv
// Directed bench for reg_ctx_engine: register-file and memory models,
// hand-computed expectations for save, restore, stall, priority, wrap and reset.
module tb_reg_ctx_engine;

    logic        clk;
    logic        rst;
    logic        start_save_i;
    logic        start_restore_i;
    logic [31:0] base_addr_i;
    logic        busy_o;
    logic        done_o;
    logic [4:0]  rf_rd_reg_o;
    logic [31:0] rf_rd_data_i;
    logic [4:0]  rf_wr_reg_o;
    logic [31:0] rf_wr_data_o;
    logic        rf_reg_write_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_write_o;
    logic        mem_read_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    reg_ctx_engine dut (
        .clk            (clk),
        .rst            (rst),
        .start_save_i   (start_save_i),
        .start_restore_i(start_restore_i),
        .base_addr_i    (base_addr_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .rf_rd_reg_o    (rf_rd_reg_o),
        .rf_rd_data_i   (rf_rd_data_i),
        .rf_wr_reg_o    (rf_wr_reg_o),
        .rf_wr_data_o   (rf_wr_data_o),
        .rf_reg_write_o (rf_reg_write_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_write_o    (mem_write_o),
        .mem_read_o     (mem_read_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_ready_i    (mem_ready_i)
    );

    int testCount = 0;
    int failCount = 0;

    logic [31:0] rf [32];
    logic        loadRf;
    logic        clearLogs;
    logic        stallEnable;
    logic [31:0] wrAddrQ [$];
    logic [31:0] wrDataQ [$];
    int          rfWrRegQ [$];
    int          readCount;
    int          doneCount;
    int          rf0Writes;
    int          stallCnt;
    int          snapCount;
    logic [31:0] snapAddr [4];
    logic [31:0] snapData [4];
    logic [31:0] snapReg  [4];

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file with combinational read and memory holding ~n at 0x2000+4n
    assign rf_rd_data_i = rf[rf_rd_reg_o];
    assign mem_rdata_i  = ~((mem_addr_o - 32'h0000_2000) >> 2);

    // Register-file writes, preload, and logging of every completed transfer
    always @(posedge clk) begin
        if (loadRf) begin
            rf[0] <= 32'h0;
            for (int n = 1; n < 32; n++) rf[n] <= 32'hA500_0000 + n;
        end else if (rf_reg_write_o) begin
            rf[rf_wr_reg_o] <= rf_wr_data_o;
        end
        if (clearLogs) begin
            wrAddrQ.delete();
            wrDataQ.delete();
            rfWrRegQ.delete();
            readCount = 0;
            doneCount = 0;
            rf0Writes = 0;
        end else begin
            if (mem_write_o && mem_ready_i) begin
                wrAddrQ.push_back(mem_addr_o);
                wrDataQ.push_back(mem_wdata_o);
            end
            if (mem_read_o && mem_ready_i) readCount++;
            if (done_o) doneCount++;
            if (rf_reg_write_o) begin
                rfWrRegQ.push_back(int'(rf_wr_reg_o));
                if (rf_wr_reg_o == 5'd0) rf0Writes++;
            end
        end
    end

    // Memory ready generator: three stall cycles on the idx=5 save write when enabled
    always @(negedge clk) begin
        if (!stallEnable) begin
            stallCnt    = 0;
            snapCount   = 0;
            mem_ready_i = 1'b1;
        end else begin
            if (mem_write_o && rf_rd_reg_o == 5'd5 && snapCount < 4) begin
                snapAddr[snapCount] = mem_addr_o;
                snapData[snapCount] = mem_wdata_o;
                snapReg[snapCount]  = {27'b0, rf_rd_reg_o};
                snapCount++;
            end
            if (mem_write_o && rf_rd_reg_o == 5'd5 && stallCnt < 3) begin
                mem_ready_i = 1'b0;
                stallCnt++;
            end else begin
                mem_ready_i = 1'b1;
            end
        end
    end

    // Count one comparison and report it if the observed value differs
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reload the register file and clear transfer logs while the engine is idle
    task automatic prepare();
        @(negedge clk);
        loadRf    = 1'b1;
        clearLogs = 1'b1;
        @(negedge clk);
        loadRf    = 1'b0;
        clearLogs = 1'b0;
    endtask

    // Start a transfer at edge 0 and return the cycle in which done is seen
    task automatic applyStimulus(input logic doSave, input logic doRestore, input logic [31:0] base,
                                 input int pulseAt, output int lat, output logic busyAtDone);
        @(negedge clk);
        start_save_i    = doSave;
        start_restore_i = doRestore;
        base_addr_i     = base;
        @(negedge clk);
        start_save_i    = 1'b0;
        start_restore_i = 1'b0;
        lat = 1;
        while (!done_o && lat < 200) begin
            start_restore_i = (lat == pulseAt);
            @(negedge clk);
            lat++;
        end
        start_restore_i = 1'b0;
        busyAtDone = busy_o;
    endtask

    // Confirm every save write went to base+4n with register n's preload value
    task automatic checkSaveLog(input string tag, input logic [31:0] base);
        int bad;
        bad = 0;
        for (int i = 0; i < wrAddrQ.size(); i++) begin
            if (wrAddrQ[i] !== base + 32'(4 * (i + 1)) || wrDataQ[i] !== 32'hA500_0000 + 32'(i + 1)) bad++;
        end
        checkOutput({tag, "_writes"}, 32'(wrAddrQ.size()), 32'd31);
        checkOutput({tag, "_badwrites"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int          lat;
        logic        bsy;
        int          wait10;
        logic [31:0] rf10Before;

        rst             = 1'b1;
        start_save_i    = 1'b0;
        start_restore_i = 1'b0;
        base_addr_i     = 32'h0;
        loadRf          = 1'b1;
        clearLogs       = 1'b1;
        stallEnable     = 1'b0;
        mem_ready_i     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        loadRf    = 1'b0;
        clearLogs = 1'b0;

        // Reset state
        checkOutput("rst_ctrl", {27'b0, busy_o, done_o, mem_write_o, mem_read_o, rf_reg_write_o}, 32'h0);
        checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
        checkOutput("rst_regs", {22'b0, rf_rd_reg_o, rf_wr_reg_o}, 32'h0);
        checkOutput("rst_wdata", mem_wdata_o, 32'h0);
        checkOutput("rst_rf_wr_data", rf_wr_data_o, 32'h0);

        // Plain save
        prepare();
        applyStimulus(1'b1, 1'b0, 32'h0000_1000, 0, lat, bsy);
        checkOutput("save_latency", 32'(lat), 32'd32);
        checkOutput("save_busy_at_done", {31'b0, bsy}, 32'h0);
        checkSaveLog("save", 32'h0000_1000);
        checkOutput("save_first_addr", wrAddrQ[0], 32'h0000_1004);
        checkOutput("save_last_data", wrDataQ[30], 32'hA500_001F);

        // Plain restore
        prepare();
        applyStimulus(1'b0, 1'b1, 32'h0000_2000, 0, lat, bsy);
        checkOutput("restore_latency", 32'(lat), 32'd63);
        @(negedge clk);
        checkOutput("restore_rf_writes", 32'(rfWrRegQ.size()), 32'd31);
        checkOutput("restore_reads", 32'(readCount), 32'd31);
        checkOutput("restore_rf0_writes", 32'(rf0Writes), 32'd0);
        checkOutput("restore_rf0", rf[0], 32'h0);
        checkOutput("restore_rf1", rf[1], 32'hFFFF_FFFE);
        checkOutput("restore_rf17", rf[17], 32'hFFFF_FFEE);
        checkOutput("restore_rf31", rf[31], 32'hFFFF_FFE0);

        // Save with three stall cycles on register 5
        prepare();
        stallEnable = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0000_1000, 0, lat, bsy);
        stallEnable = 1'b0;
        checkOutput("stall_latency", 32'(lat), 32'd35);
        checkSaveLog("stall", 32'h0000_1000);
        checkOutput("stall_hold_cycles", 32'(snapCount), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("stall_addr%0d", i), snapAddr[i], 32'h0000_1014);
            checkOutput($sformatf("stall_data%0d", i), snapData[i], 32'hA500_0005);
            checkOutput($sformatf("stall_reg%0d", i), snapReg[i], 32'd5);
        end

        // Both starts together, then a restore pulse mid-save
        prepare();
        applyStimulus(1'b1, 1'b1, 32'h0000_1000, 10, lat, bsy);
        checkOutput("prio_latency", 32'(lat), 32'd32);
        repeat (3) @(negedge clk);
        checkOutput("prio_idle_busy", {31'b0, busy_o}, 32'h0);
        checkOutput("prio_reads", 32'(readCount), 32'd0);
        checkOutput("prio_done_count", 32'(doneCount), 32'd1);
        checkSaveLog("prio", 32'h0000_1000);

        // Misaligned base near the top of the address space
        prepare();
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FF83, 0, lat, bsy);
        checkOutput("wrap_first_addr", wrAddrQ[0], 32'hFFFF_FF84);
        checkOutput("wrap_last_addr", wrAddrQ[30], 32'hFFFF_FFFC);
        checkSaveLog("wrap", 32'hFFFF_FF80);

        // Reset during the write-back of register 10
        prepare();
        rf10Before = rf[10];
        @(negedge clk);
        start_restore_i = 1'b1;
        base_addr_i     = 32'h0000_2000;
        @(negedge clk);
        start_restore_i = 1'b0;
        wait10 = 0;
        while (!(rf_reg_write_o && rf_wr_reg_o == 5'd10) && wait10 < 100) begin
            @(negedge clk);
            wait10++;
        end
        checkOutput("rstwb_reached", 32'(wait10 < 100), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstwb_ctrl", {27'b0, busy_o, done_o, mem_write_o, mem_read_o, rf_reg_write_o}, 32'h0);
        checkOutput("rstwb_mem_addr", mem_addr_o, 32'h0);
        checkOutput("rstwb_regs", {22'b0, rf_rd_reg_o, rf_wr_reg_o}, 32'h0);
        checkOutput("rstwb_rf_wr_data", rf_wr_data_o, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("rstwb_rf10", rf[10], rf10Before);
        checkOutput("rstwb_rf9", rf[9], 32'hFFFF_FFF6);
        checkOutput("rstwb_rf_writes", 32'(rfWrRegQ.size()), 32'd9);
        checkOutput("rstwb_done_count", 32'(doneCount), 32'd0);

        prepare();
        applyStimulus(1'b0, 1'b1, 32'h0000_2000, 0, lat, bsy);
        checkOutput("fresh_latency", 32'(lat), 32'd63);
        @(negedge clk);
        checkOutput("fresh_first_reg", 32'(rfWrRegQ.size() > 0 ? rfWrRegQ[0] : -1), 32'd1);
        checkOutput("fresh_rf10", rf[10], 32'hFFFF_FFF5);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/reg_ctx_engine.md
Name: reg_ctx_engine

Overview:
- Context save/restore sequencer that acts as the reader and writer of the 32x32 register file.
- Save: reads registers 1..31 through the register-file read port and streams them to data memory.
- Restore: reads 31 words back from memory and writes them into registers 1..31 through the register-file write port.
- Sits beside the datapath and is used for trap entry/exit and for test dumps. The datapath must not drive the register-file ports while busy=1.

Parameters:
- FIRST_REG, 1, first register index transferred (register 0 is hardwired zero and is never transferred).
- LAST_REG, 31, last register index transferred.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- start_save  input  1  request a save; sampled only in IDLE.
- start_restore  input  1  request a restore; sampled only in IDLE.
- base_addr  input  32  memory base byte address; latched at start.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- rf_rd_reg  output  5  register-file read address.
- rf_rd_data  input  32  register-file read data (combinational read).
- rf_wr_reg  output  5  register-file write address.
- rf_wr_data  output  32  register-file write data.
- rf_reg_write  output  1  register-file write enable.
- mem_addr  output  32  memory byte address.
- mem_wdata  output  32  memory write data.
- mem_write  output  1  memory write request.
- mem_read  output  1  memory read request.
- mem_rdata  input  32  memory read data, valid in the cycle mem_ready=1.
- mem_ready  input  1  memory accept/complete strobe.

Behaviour:
- States: IDLE, SAVE_REQ, RESTORE_REQ, RESTORE_WB, DONE.
- Reset: state=IDLE, idx=FIRST_REG, base=0, data capture=0. All outputs 0 (busy, done, rf_reg_write, mem_write, mem_read, addresses, data).
- Reset mid-operation wins in the same edge. No rf write occurs on the reset cycle, and no done pulse is issued.
- IDLE:
  - start_save=1 -> SAVE_REQ.
  - else start_restore=1 -> RESTORE_REQ. Save has priority when both are high.
  - On either start: latch base = {base_addr[31:2], 2'b00} and set idx=FIRST_REG.
  - Starts asserted in any non-IDLE state are ignored; there is no queuing.
- Address rule: mem_addr = base + {25'b0, idx, 2'b00}, modulo 2^32. Slot 0 of the save area is unused, so register n lives at base+4n.
- Handshake:
  - A request (mem_write or mem_read) is held with stable mem_addr and data until a cycle with mem_ready=1. The transfer completes in that cycle.
  - mem_ready while no request is pending is ignored.
- SAVE_REQ:
  - Drive rf_rd_reg=idx, mem_write=1, and mem_wdata=rf_rd_data (combinational pass-through).
  - On mem_ready: if idx==LAST_REG -> DONE; else idx+1 and stay in SAVE_REQ.
- RESTORE_REQ:
  - Drive mem_read=1.
  - On mem_ready: capture mem_rdata -> RESTORE_WB.
- RESTORE_WB:
  - Drive rf_reg_write=1, rf_wr_reg=idx, rf_wr_data=capture for exactly one cycle. No memory request is driven.
  - Then: if idx==LAST_REG -> DONE; else idx+1 -> RESTORE_REQ.
- DONE: done=1, busy=0, all requests 0, for one cycle -> IDLE.
- Busy: busy=1 in SAVE_REQ, RESTORE_REQ and RESTORE_WB.
- When no memory or rf access is active, mem_write, mem_read and rf_reg_write are 0. Address outputs may hold their last value.
- Latency with mem_ready tied to 1, start sampled at edge 0:
  - Save: SAVE_REQ occupies cycles 1..31; done=1 in cycle 32.
  - Restore: REQ/WB alternate over cycles 1..62; done=1 in cycle 63.
  - Each stall cycle with mem_ready=0 adds one cycle.
- Register 0 is never read via rf_rd_reg and never written.

Test Plan:
- Save with mem_ready=1, base_addr=0x0000_1000, register n preloaded with 0xA500_0000+n:
  - Expect 31 writes, with addr 0x1004..0x107C carrying data 0xA500_0001..0xA500_001F.
  - Expect done in cycle 32, busy low in cycle 32, and no write to 0x1000.
- Restore with mem_ready=1, memory word at 0x2000+4n = ~n:
  - Expect rf_reg_write pulses for regs 1..31 with data ~n, and reg 0 untouched.
  - Expect done in cycle 63.
- Save with mem_ready low for 3 cycles on idx=5:
  - mem_addr, mem_wdata and rf_rd_reg are held stable for 4 cycles.
  - Total done latency is 35; no duplicate write occurs.
- start_save=1 and start_restore=1 in the same cycle:
  - Save runs and no mem_read occurs.
  - start_restore pulsed during the save is ignored, and the block is back in IDLE after the done pulse.
- Wrap and alignment, base_addr=0xFFFF_FF83:
  - The latched base is 0xFFFF_FF80.
  - reg 31 maps to 0xFFFF_FFFC, and reg 1 to 0xFFFF_FF84.
- rst asserted in RESTORE_WB at idx=10:
  - No rf write occurs that cycle and no done pulse is issued.
  - All outputs are 0 next cycle.
  - A fresh restore then starts at idx=1.
